// File: rtl/spi_flash_owner_arbiter_if.sv
// Signal bundle between the two SPI masters, the arbiter and the flash pins.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives both requesting masters and models the flash.
interface spi_flash_owner_arbiter_if;
  // JTAG (BSCAN USER1) master side
  logic jtag_req;
  logic jtag_sck;
  logic jtag_csn;
  logic jtag_sdi;
  logic jtag_sdo;
  logic jtag_gnt;
  // Fabric SPI command engine side
  logic usr_req;
  logic usr_gnt;
  logic usr_sck;
  logic usr_csn;
  logic usr_sdi;
  logic usr_sdo;
  logic usr_revoked;
  // Flash pins (or STARTUP USRCCLKO/FCSBO)
  logic flash_sck;
  logic flash_csn;
  logic flash_sdi;
  logic flash_sdo;
  logic flash_wpn;
  logic flash_hldn;

  modport slave (
    input  jtag_req, jtag_sck, jtag_csn, jtag_sdi,
    input  usr_req, usr_sck, usr_csn, usr_sdi,
    input  flash_sdo,
    output jtag_sdo, jtag_gnt,
    output usr_gnt, usr_sdo, usr_revoked,
    output flash_sck, flash_csn, flash_sdi, flash_wpn, flash_hldn
  );

  modport master (
    output jtag_req, jtag_sck, jtag_csn, jtag_sdi,
    output usr_req, usr_sck, usr_csn, usr_sdi,
    output flash_sdo,
    input  jtag_sdo, jtag_gnt,
    input  usr_gnt, usr_sdo, usr_revoked,
    input  flash_sck, flash_csn, flash_sdi, flash_wpn, flash_hldn
  );
endinterface

// File: rtl/spi_flash_owner_arbiter.sv
// Ownership arbiter for one configuration SPI flash shared by the JTAG bridge
// and a fabric SPI engine. Ownership is non-preemptive except for the revoke
// of an idle user session while JTAG waits; every hand-over passes through a
// CS-high guard gap. The SPI datapath is a pure combinational mux selected by
// the registered owner state, so SPI clocks never pass through a flop.
module spi_flash_owner_arbiter #(
  parameter int SYNC_STAGES   = 2,
  parameter int GUARD_CYCLES  = 4,
  parameter int REVOKE_CYCLES = 1024
) (
  input logic                      clk,
  input logic                      rst,
  spi_flash_owner_arbiter_if.slave bus
);

  // Counters only need to reach LAST = N-1; the exit decision is taken on the
  // cycle the counter already holds LAST, so the state lasts exactly N cycles.
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int RW = (REVOKE_CYCLES > 1) ? $clog2(REVOKE_CYCLES) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'((REVOKE_CYCLES > 0) ? (REVOKE_CYCLES - 1) : 0);
  localparam bit            REV_EN = (REVOKE_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_JTAG  = 2'd1,
    ST_USER  = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   guard_cnt_q, guard_cnt_d;
  logic [RW-1:0]   rev_cnt_q, rev_cnt_d;
  logic            revoked_q, revoked_d;

  logic [SYNC_STAGES-1:0] req_sync;
  logic [SYNC_STAGES-1:0] csn_sync;
  logic                   j_req;
  logic                   j_csn;

  logic fl_sck, fl_csn, fl_sdi;
  logic j_sdo, u_sdo;

  // JTAG-side request and chip-select cross into clk; both clear to the idle level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_sync <= '0;
      csn_sync <= '1;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], bus.jtag_req};
      csn_sync <= {csn_sync[SYNC_STAGES-2:0], bus.jtag_csn};
    end
  end

  assign j_req = req_sync[SYNC_STAGES-1];
  assign j_csn = csn_sync[SYNC_STAGES-1];

  // Owner state, guard/revoke counters and the revoke pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      guard_cnt_q <= '0;
      rev_cnt_q   <= '0;
      revoked_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      guard_cnt_q <= guard_cnt_d;
      rev_cnt_q   <= rev_cnt_d;
      revoked_q   <= revoked_d;
    end
  end

  // Next owner: JTAG wins ties in IDLE; JTAG leaves only with its CS released;
  // an idle user session is revoked after REVOKE_CYCLES of JTAG waiting
  always_comb begin
    state_d     = state_q;
    guard_cnt_d = '0;
    rev_cnt_d   = '0;
    revoked_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (j_req) begin
          state_d = ST_JTAG;
        end else if (bus.usr_req) begin
          state_d = ST_USER;
        end
      end
      ST_JTAG: begin
        if (!j_req && j_csn) begin
          state_d = ST_GUARD;
        end
      end
      ST_USER: begin
        if (!bus.usr_req) begin
          state_d = ST_GUARD;
        end else if (REV_EN && j_req && bus.usr_csn) begin
          // Counter clears (default) on any cycle this condition breaks.
          if (rev_cnt_q >= R_LAST) begin
            state_d   = ST_GUARD;
            revoked_d = 1'b1;
          end else begin
            rev_cnt_d = rev_cnt_q + RW'(1);
          end
        end
      end
      ST_GUARD: begin
        if (guard_cnt_q >= G_LAST) begin
          state_d = ST_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin mux keyed on the registered owner; non-owners are parked, and reset
  // forces every MISO return high immediately
  always_comb begin
    fl_sck = 1'b0;
    fl_csn = 1'b1;
    fl_sdi = 1'b0;
    j_sdo  = bus.jtag_sdi;
    u_sdo  = 1'b1;
    if (rst) begin
      j_sdo = 1'b1;
    end else begin
      case (state_q)
        ST_JTAG: begin
          fl_sck = bus.jtag_sck;
          fl_csn = bus.jtag_csn;
          fl_sdi = bus.jtag_sdi;
          j_sdo  = bus.flash_sdo;
        end
        ST_USER: begin
          fl_sck = bus.usr_sck;
          fl_csn = bus.usr_csn;
          fl_sdi = bus.usr_sdi;
          u_sdo  = bus.flash_sdo;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.flash_sck   = fl_sck;
  assign bus.flash_csn   = fl_csn;
  assign bus.flash_sdi   = fl_sdi;
  assign bus.jtag_sdo    = j_sdo;
  assign bus.usr_sdo     = u_sdo;
  assign bus.flash_wpn   = 1'b1;
  assign bus.flash_hldn  = 1'b1;
  assign bus.jtag_gnt    = (state_q == ST_JTAG);
  assign bus.usr_gnt     = (state_q == ST_USER);
  assign bus.usr_revoked = revoked_q;

endmodule

// File: tb/tb_spi_flash_owner_arbiter.sv
// Directed bench for spi_flash_owner_arbiter (SYNC_STAGES=2, GUARD_CYCLES=4,
// REVOKE_CYCLES=16). Inputs change 1 ns after the rising edge; outputs are
// sampled there or 1 ns after an input change.
module tb_spi_flash_owner_arbiter;

  localparam int GUARD  = 4;
  localparam int REVOKE = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  spi_flash_owner_arbiter_if bus ();

  spi_flash_owner_arbiter #(
    .SYNC_STAGES   (2),
    .GUARD_CYCLES  (GUARD),
    .REVOKE_CYCLES (REVOKE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] mosi_byte;
  logic [7:0] miso_byte;
  logic [7:0] cmd;
  logic [7:0] rsp;
  int         pulses;
  int         pulse_at;
  int         waited;

  initial begin
    checks = 0;
    errors = 0;
    cmd = 8'h9F;
    rsp = 8'hA5;
    rst = 1'b1;
    bus.jtag_req  = 1'b0;
    bus.jtag_sck  = 1'b0;
    bus.jtag_csn  = 1'b1;
    bus.jtag_sdi  = 1'b0;
    bus.usr_req   = 1'b0;
    bus.usr_sck   = 1'b0;
    bus.usr_csn   = 1'b1;
    bus.usr_sdi   = 1'b0;
    bus.flash_sdo = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_jtag_gnt", bus.jtag_gnt, 1'b0);
    check("rst_usr_gnt", bus.usr_gnt, 1'b0);
    check("rst_revoked", bus.usr_revoked, 1'b0);
    check("rst_flash_csn", bus.flash_csn, 1'b1);
    check("rst_flash_sck", bus.flash_sck, 1'b0);
    check("rst_flash_sdi", bus.flash_sdi, 1'b0);
    check("rst_jtag_sdo", bus.jtag_sdo, 1'b1);
    check("rst_usr_sdo", bus.usr_sdo, 1'b1);
    check("wpn_hldn", {bus.flash_wpn, bus.flash_hldn}, 2'b11);
    rst = 1'b0;
    tick();
    check("idle_no_gnt", {bus.jtag_gnt, bus.usr_gnt}, 2'b00);

    // User session: grant one clk after request, 0x9F out, 0xA5 back
    bus.usr_req = 1'b1;
    #1;
    check("usr_gnt_before_edge", bus.usr_gnt, 1'b0);
    tick();
    check("usr_gnt_after_1clk", bus.usr_gnt, 1'b1);
    bus.usr_csn = 1'b0;
    #1;
    check("usr_flash_csn_low", bus.flash_csn, 1'b0);
    mosi_byte = 8'h00;
    miso_byte = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      bus.usr_sdi   = cmd[i];
      bus.flash_sdo = rsp[i];
      bus.usr_sck   = 1'b0;
      #1;
      check("usr_sck_low_follow", bus.flash_sck, 1'b0);
      bus.usr_sck = 1'b1;
      #1;
      check("usr_sck_high_follow", bus.flash_sck, 1'b1);
      mosi_byte = {mosi_byte[6:0], bus.flash_sdi};
      miso_byte = {miso_byte[6:0], bus.usr_sdo};
      tick();
    end
    bus.usr_sck = 1'b0;
    check("usr_mosi_byte", mosi_byte, 8'h9F);
    check("usr_miso_byte", miso_byte, 8'hA5);
    bus.jtag_sdi = 1'b1;
    #1;
    check("usr_jtag_bypass_1", bus.jtag_sdo, 1'b1);
    bus.jtag_sdi = 1'b0;
    #1;
    check("usr_jtag_bypass_0", bus.jtag_sdo, 1'b0);

    // Release: guard keeps flash deselected even with usr_csn low, then regrant
    bus.usr_csn = 1'b1;
    bus.usr_req = 1'b0;
    tick();
    check("release_gnt_low", bus.usr_gnt, 1'b0);
    bus.usr_req = 1'b1;
    bus.usr_csn = 1'b0;
    for (int k = 0; k < GUARD; k++) begin
      tick();
      check("guard_no_gnt", bus.usr_gnt, 1'b0);
      check("guard_csn_high", bus.flash_csn, 1'b1);
    end
    // GUARD has now run its 4 cycles; the IDLE cycle takes the request
    check("guard_exit_idle_no_gnt", bus.usr_gnt, 1'b0);
    tick();
    check("regrant_usr", bus.usr_gnt, 1'b1);
    check("regrant_csn_follow", bus.flash_csn, 1'b0);

    // Reset mid-USER with usr_csn low and usr_sck high
    bus.usr_sck = 1'b1;
    #1;
    check("pre_rst_sck_follow", bus.flash_sck, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_flash_csn", bus.flash_csn, 1'b1);
    check("midrst_flash_sck", bus.flash_sck, 1'b0);
    check("midrst_usr_gnt", bus.usr_gnt, 1'b0);
    tick();
    bus.usr_req = 1'b0;
    bus.usr_csn = 1'b1;
    bus.usr_sck = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_idle", {bus.jtag_gnt, bus.usr_gnt}, 2'b00);

    // JTAG priority when both are visible in IDLE in the same cycle
    bus.jtag_req = 1'b1;
    tick();
    check("jtag_sync_clk1", bus.jtag_gnt, 1'b0);
    tick();
    check("jtag_sync_clk2", bus.jtag_gnt, 1'b0);
    bus.usr_req = 1'b1;
    tick();
    check("jtag_gnt_clk3", bus.jtag_gnt, 1'b1);
    check("usr_loses_tie", bus.usr_gnt, 1'b0);

    // Isolation while JTAG owns
    bus.jtag_csn  = 1'b0;
    bus.jtag_sck  = 1'b1;
    bus.jtag_sdi  = 1'b1;
    bus.usr_csn   = 1'b1;
    bus.usr_sck   = 1'b0;
    bus.flash_sdo = 1'b0;
    #1;
    check("jtag_pins", {bus.flash_csn, bus.flash_sck, bus.flash_sdi}, 3'b011);
    check("jtag_sdo_from_flash", bus.jtag_sdo, 1'b0);
    bus.usr_csn  = 1'b0;
    bus.usr_sck  = 1'b1;
    bus.jtag_sck = 1'b0;
    bus.jtag_csn = 1'b1;
    bus.usr_sdi  = 1'b1;
    bus.jtag_sdi = 1'b0;
    bus.flash_sdo = 1'b1;
    #1;
    check("jtag_ignores_usr", {bus.flash_csn, bus.flash_sck, bus.flash_sdi}, 3'b100);
    check("jtag_usr_sdo_high", bus.usr_sdo, 1'b1);
    check("jtag_sdo_from_flash1", bus.jtag_sdo, 1'b1);
    bus.usr_csn  = 1'b1;
    bus.usr_sck  = 1'b0;
    bus.usr_sdi  = 1'b0;
    bus.flash_sdo = 1'b0;

    // JTAG drops request mid-transfer: held until its CS-high is synchronized
    bus.jtag_csn = 1'b0;
    tick();
    bus.jtag_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("jtag_hold_csn_low", bus.jtag_gnt, 1'b1);
    end
    bus.jtag_csn = 1'b1;
    tick();
    check("jtag_csn_sync1", bus.jtag_gnt, 1'b1);
    tick();
    check("jtag_csn_sync2", bus.jtag_gnt, 1'b1);
    tick();
    check("jtag_to_guard", bus.jtag_gnt, 1'b0);
    for (int k = 0; k < GUARD; k++) begin
      tick();
      check("jtag_guard_usr_wait", bus.usr_gnt, 1'b0);
    end
    tick();
    check("usr_after_jtag_guard", bus.usr_gnt, 1'b1);

    // Revoke: user idle (usr_csn high) while JTAG waits
    bus.usr_csn  = 1'b1;
    bus.jtag_req = 1'b1;
    pulses   = 0;
    pulse_at = 0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (bus.usr_revoked === 1'b1) begin
        pulses++;
        pulse_at = k;
      end
      if (k == 17) check("revoke_still_user", bus.usr_gnt, 1'b1);
      if (k == 18) check("revoke_gnt_drop", bus.usr_gnt, 1'b0);
    end
    check("revoke_pulse_count", pulses, 16'd1);
    check("revoke_pulse_clk", pulse_at, 16'd18);
    // Guard entered at clk 18; IDLE after clk 22; JTAG at clk 23
    for (int k = 20; k <= 22; k++) begin
      tick();
      check("revoke_guard_no_jtag", bus.jtag_gnt, 1'b0);
    end
    tick();
    check("jtag_after_revoke", bus.jtag_gnt, 1'b1);
    check("usr_not_regranted", bus.usr_gnt, 1'b0);

    // JTAG releases; held usr_req gets the flash back via GUARD/IDLE
    bus.jtag_req = 1'b0;
    waited = 0;
    while (bus.usr_gnt !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check("usr_regrant_found", bus.usr_gnt, 1'b1);
    check("usr_regrant_latency", waited, 16'd8);

    // No revoke when the user keeps selecting the flash every 10 clks
    bus.jtag_req = 1'b1;
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      bus.usr_csn = (k % 10 == 0) ? 1'b0 : 1'b1;
      tick();
      if (bus.usr_revoked === 1'b1) pulses++;
    end
    check("active_user_no_revoke", pulses, 16'd0);
    check("active_user_keeps_gnt", bus.usr_gnt, 1'b1);

    bus.usr_csn  = 1'b1;
    bus.usr_req  = 1'b0;
    bus.jtag_req = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("final_idle", {bus.jtag_gnt, bus.usr_gnt, bus.flash_csn}, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
